// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a receive FIFO and a registered head.
// The line is oversampled at CLKS_PER_BIT clocks per bit, with sticky frame-error and overflow flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rx,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clear_err
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(DEPTH);
  localparam logic [BW-1:0]    HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]    FULL_M1 = BW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  logic             rx_meta_q, rx_s_q;
  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, frame_set;

  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic             pop, full, push_ok, drop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // The synchroniser resets to the idle-high level so no false start edge follows reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d          = '0;
          shift_d[idx_q]  = rx_s_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign full    = (count_q == CNT_MAX);
  assign pop     = (count_q != '0) && rd_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    // The head register is fed straight from the shifter when the pushed byte becomes the head.
    if (push_ok && (count_q == '0 || (count_q == CNT_W'(1) && pop)))
      rd_data_d = shift_q;
    else if (pop && count_q > CNT_W'(1))
      rd_data_d = mem_q[rd_ptr_q + PW'(1)];
  end

  assign frame_err_d = frame_set | (frame_err_q & ~clear_err);
  assign overflow_d  = drop      | (overflow_q  & ~clear_err);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;
  logic       clear_err;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clear_err  (clear_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One frame; pop_at_stop raises rd_ready for exactly the stop-sample cycle.
  task automatic send_byte(input logic [7:0] b, input logic stop_val,
                           input int stop_bits, input logic pop_at_stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_val;
    for (int i = 0; i < CPB * stop_bits; i++) begin
      rd_ready = pop_at_stop && (i == 6);
      @(negedge clock);
    end
    rd_ready = 1'b0;
    rx = 1'b1;
    idle(CPB);
  endtask

  task automatic pulse_ready();
    rd_ready = 1'b1;
    @(negedge clock);
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    rx        = 1'b1;
    rd_ready  = 1'b0;
    clear_err = 1'b0;
    reset_n   = 1'b0;
    idle(3);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    idle(4);

    // Two bytes at exact baud, then pops.
    send_byte(8'h55, 1'b1, 1, 1'b0);
    send_byte(8'hA3, 1'b1, 1, 1'b0);
    check("two_count", fifo_count, 2);
    check("two_valid", rd_valid, 1);
    check("two_head", rd_data, 8'h55);
    pulse_ready();
    check("pop1_head", rd_data, 8'hA3);
    check("pop1_count", fifo_count, 1);
    pulse_ready();
    check("pop2_count", fifo_count, 0);
    check("pop2_valid", rd_valid, 0);
    pulse_ready();
    check("empty_pop_count", fifo_count, 0);
    check("empty_pop_valid", rd_valid, 0);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(2 * CPB);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", frame_err, 0);

    // Stop bit held low for 20 bit times, then a good frame, then clear.
    send_byte(8'h3C, 1'b0, 20, 1'b0);
    check("break_ferr", frame_err, 1);
    check("break_count", fifo_count, 0);
    send_byte(8'h7E, 1'b1, 1, 1'b0);
    check("after_break_count", fifo_count, 1);
    check("after_break_head", rd_data, 8'h7E);
    check("ferr_sticky", frame_err, 1);
    pulse_clear();
    check("ferr_cleared", frame_err, 0);
    pulse_ready();
    check("after_break_drain", fifo_count, 0);

    // Overflow: five bytes into four entries.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1, 1'b0);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      check("ovf_drain_data", rd_data, exp_b);
      pulse_ready();
    end
    check("ovf_drain_count", fifo_count, 0);
    check("ovf_sticky", overflow, 1);
    pulse_clear();
    check("ovf_cleared", overflow, 0);

    // Full FIFO with a pop in the stop-sample cycle.
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 1, 1'b0);
    check("full_count", fifo_count, 4);
    send_byte(8'h99, 1'b1, 1, 1'b1);
    check("fullpop_count", fifo_count, 4);
    check("fullpop_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      exp_b = (i == 3) ? 8'h99 : 8'h12 + 8'(i);
      check("fullpop_drain", rd_data, exp_b);
      pulse_ready();
    end
    check("fullpop_empty", fifo_count, 0);

    // Reset during data bit 4 of 0xF0, with one byte already buffered.
    send_byte(8'h5A, 1'b1, 1, 1'b0);
    check("pre_reset_count", fifo_count, 1);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) idle(CPB);
    rx = 1'b1;
    idle(3);
    reset_n = 1'b0;
    idle(2);
    check("midreset_count", fifo_count, 0);
    check("midreset_data", rd_data, 0);
    reset_n = 1'b1;
    idle(2 * CPB);
    check("post_reset_count", fifo_count, 0);
    send_byte(8'h12, 1'b1, 1, 1'b0);
    check("post_reset_rx_count", fifo_count, 1);
    check("post_reset_rx_head", rd_data, 8'h12);
    check("post_reset_ferr", frame_err, 0);
    check("post_reset_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver with a receive FIFO. It sits directly upstream of the CPU core's UART receive port on the Tang Nano 9K board.
- Oversamples the asynchronous board pin `rx` and assembles 8N1 frames.
- Buffers received bytes in a FIFO and presents them to the core through a valid/ready read interface.
- Flags framing errors and overflow so software can detect lost data.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); minimum 4.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the fill-level output.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- rx  in  1  raw UART line from the board pin; idle high; asynchronous to clock.
- rd_data  out  8  byte at the FIFO head.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- fifo_count  out  CNT_W  number of bytes currently stored.
- frame_err  out  1  sticky; set when a stop bit is sampled low.
- overflow  out  1  sticky; set when a completed byte is dropped because the FIFO is full.
- clear_err  in  1  synchronous clear of frame_err and overflow.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM=IDLE; bit counter and baud counter = 0.
  - Both synchroniser flops = 1.
  - FIFO empty.
  - Outputs: rd_valid=0, rd_data=0, fifo_count=0, frame_err=0, overflow=0.
  - A reset mid-frame abandons the partial byte; nothing is pushed.
- Synchroniser: 2-flop chain on rx. All logic below uses rx_s, the second flop's output.
- FSM states and transitions:
  - IDLE: rx_s==0 → START, baud counter cleared.
  - START: at baud count CLKS_PER_BIT/2-1, sample rx_s.
    - 0 → DATA, counter cleared, bit index 0.
    - 1 → IDLE; the event is a glitch, no flag is raised.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit index], LSB first. After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 → push byte (see push rules below), then IDLE.
    - 0 → set frame_err, discard byte, go to BREAK.
  - BREAK: wait until rx_s==1, then IDLE. This prevents a held-low line (break) from re-triggering starts.
- Push rules:
  - A push is a single-cycle strobe in the stop-sample cycle.
  - Push when full and no pop in the same cycle → byte dropped, overflow set, FIFO unchanged.
  - Push when full with a pop in the same cycle → both occur; fifo_count stays at DEPTH; no overflow.
- Pop:
  - rd_valid && rd_ready pops the head.
  - rd_ready while empty has no effect.
- Simultaneous push and pop when not full or empty → fifo_count unchanged.
- Latency:
  - The pushed byte is visible at the next clock edge after the push strobe: rd_valid=1, fifo_count incremented.
  - rd_data is registered head data, updated the same edge.
  - When the FIFO is empty, a push writes directly to the head; there is no extra bubble cycle.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count is tracked separately, 0..DEPTH inclusive.
- Error flags:
  - Stay set until clear_err=1 (1 cycle).
  - Set wins over clear in the same cycle.
  - The flags do not block reception.
- End-to-end latency: the stop-bit sample falls about 9.5 bit times after the start edge, plus 2 synchroniser cycles.

Test Plan:
- CLKS_PER_BIT=8, send 0x55 then 0xA3 at exact baud, rd_ready=0 → fifo_count=2, rd_data=0x55; one rd_ready pulse → rd_data=0xA3, fifo_count=1.
- rx low for 3 cycles, then high (glitch shorter than half a bit) → FSM returns to IDLE, fifo_count=0, frame_err=0.
- Frame 0x3C with stop bit held low for 20 bit times → frame_err=1, fifo_count=0. Then a valid 0x7E → fifo_count=1, rd_data=0x7E. Then clear_err → frame_err=0.
- DEPTH=4, send 5 bytes 0x01..0x05 with rd_ready=0 → fifo_count=4, overflow=1. Drain and read 0x01,0x02,0x03,0x04.
- DEPTH=4, FIFO full, rd_ready held 1 during the stop-bit sample of 0x99 → no overflow, fifo_count=4, 0x99 read last.
- Assert reset_n low during DATA bit 4 of 0xF0, release, send 0x12 → only 0x12 received, fifo_count=1, all flags 0.
